// File: rtl/rgb_led_arbiter.sv
// -----------------------------------------------------------------------------
// rgb_led_arbiter
//
// Shares one on-chip RGB LED driver between NREQ status sources. The LED is
// granted round-robin. Each grant is held for a minimum display time, measured
// in prescaled ticks. The owner's {blu,grn,red} duty word drives three
// glitch-free PWM channels.
//
// Ports
//   int_osc    in   system clock (HF oscillator)
//   rst        in   synchronous, active-high reset
//   req        in   [NREQ] level-sensitive request per source
//   req_color  in   [NREQ*3*PWM_BITS] per-source {blu,grn,red} duty;
//                   source i lives at [i*3*PWM_BITS +: 3*PWM_BITS]
//   grant      out  [NREQ] one-hot owner, zero when idle
//   busy       out  high while a grant is active
//   rgb0_pwm   out  red PWM   (RGB0PWM)
//   rgb1_pwm   out  green PWM (RGB1PWM)
//   rgb2_pwm   out  blue PWM  (RGB2PWM)
//   rgb_en     out  RGBLEDEN, high while busy
//   curr_en    out  CURREN, high from the first cycle after reset release
//
// Handshake: req is a level. grant follows one cycle after a req is seen in
// IDLE. Once granted, the owner keeps the LED until the hold time expires,
// whatever happens to req. Arbitration then runs again on the req levels
// present in the hold_done cycle. All outputs are registered.
// -----------------------------------------------------------------------------
module rgb_led_arbiter #(
    parameter int NREQ       = 4,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 48000,
    parameter int HOLD_TICKS = 16
) (
    input  logic                       int_osc,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*3*PWM_BITS-1:0] req_color,
    output logic [NREQ-1:0]            grant,
    output logic                       busy,
    output logic                       rgb0_pwm,
    output logic                       rgb1_pwm,
    output logic                       rgb2_pwm,
    output logic                       rgb_en,
    output logic                       curr_en
);

    localparam int CW = 3 * PWM_BITS;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [PW-1:0]       PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [HW-1:0]       HOLD_MAX  = HW'(HOLD_TICKS);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
    localparam logic [IW-1:0]       LAST_RST  = IW'(NREQ - 1);
    localparam logic [NREQ-1:0]     ONE_HOT0  = NREQ'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    // Registered state
    state_t              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [IW-1:0]       last_q, last_d;
    logic [CW-1:0]       shadow_q, shadow_d;
    logic [CW-1:0]       active_q, active_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [2:0]          pwm_q, pwm_d;
    logic                busy_q, busy_d;
    logic                rgb_en_q, rgb_en_d;
    logic                curr_en_q, curr_en_d;

    // Per-source duty words, unpacked for indexing by source number
    logic [CW-1:0] colors [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_colors
        assign colors[g] = req_color[g*CW +: CW];
    end

    // Round-robin pick: first set req searching from last_q+1 upwards,
    // wrapping. The previous owner is examined last, so it only wins again
    // when nobody else is asking.
    logic          any_req;
    logic [IW-1:0] winner;

    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        found  = 1'b0;
        winner = last_q;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_q) + k) % NREQ);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

    logic tick;
    logic hold_done;

    assign tick      = (presc_q == PRESC_MAX);
    assign hold_done = (hold_q == HOLD_MAX);

    // Arbitration FSM, prescaler and hold counter
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        shadow_d = shadow_q;
        presc_d  = presc_q;
        hold_d   = hold_q;

        case (state_q)
            S_IDLE: begin
                grant_d  = '0;
                shadow_d = '0;
                presc_d  = '0;
                hold_d   = '0;
                if (any_req) begin
                    state_d  = S_SHOW;
                    grant_d  = ONE_HOT0 << winner;
                    last_d   = winner;
                    shadow_d = colors[winner];
                end
            end

            S_SHOW: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick && !hold_done) begin
                    hold_d = hold_q + HW'(1);
                end
                // last_q always names the current owner while showing
                if (req[last_q]) begin
                    shadow_d = colors[last_q];
                end
                if (hold_done) begin
                    presc_d = '0;
                    hold_d  = '0;
                    if (any_req) begin
                        grant_d  = ONE_HOT0 << winner;
                        last_d   = winner;
                        shadow_d = colors[winner];
                    end else begin
                        state_d  = S_IDLE;
                        grant_d  = '0;
                        shadow_d = '0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d    = (state_d == S_SHOW);
        rgb_en_d  = (state_d == S_SHOW);
        curr_en_d = 1'b1;
    end

    // PWM: shadow moves to active only as the counter wraps, so a period
    // always completes with the duty it started with.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        active_d  = (pwm_cnt_q == PWM_MAX) ? shadow_q : active_q;
        pwm_d[0]  = (pwm_cnt_q < active_q[0          +: PWM_BITS]);
        pwm_d[1]  = (pwm_cnt_q < active_q[PWM_BITS   +: PWM_BITS]);
        pwm_d[2]  = (pwm_cnt_q < active_q[2*PWM_BITS +: PWM_BITS]);
    end

    always_ff @(posedge int_osc) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= LAST_RST;
            shadow_q  <= '0;
            active_q  <= '0;
            pwm_cnt_q <= '0;
            presc_q   <= '0;
            hold_q    <= '0;
            pwm_q     <= '0;
            busy_q    <= 1'b0;
            rgb_en_q  <= 1'b0;
            curr_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pwm_cnt_q <= pwm_cnt_d;
            presc_q   <= presc_d;
            hold_q    <= hold_d;
            pwm_q     <= pwm_d;
            busy_q    <= busy_d;
            rgb_en_q  <= rgb_en_d;
            curr_en_q <= curr_en_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign rgb0_pwm = pwm_q[0];
    assign rgb1_pwm = pwm_q[1];
    assign rgb2_pwm = pwm_q[2];
    assign rgb_en   = rgb_en_q;
    assign curr_en  = curr_en_q;

endmodule
